ahb_mem_test_master: RTL

- AHB-Lite master in the FPGA fabric that drives the memory-controller AHB slave port, the responder end of the existing AHB slave-to-SRAM path.
- On start, it writes a seeded pattern to WORDS consecutive 32-bit locations from BASE_ADDR, reads them back and compares.
- Reports pass/fail, error count, first failing address and bus errors.
- Used for board bring-up and for SRAM/ECC-path checking after IAP reprogramming.

---
 rtl/ahb_mem_test_pkg.sv | 28 ++
 rtl/ahb_mem_test_if.sv | 27 ++
 rtl/ahb_mem_test_cmp.sv | 58 +++++
 rtl/ahb_mem_test_master.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ahb_mem_test_pkg.sv
// Shared constants, FSM encoding and pattern generator
// for the AHB-Lite SRAM test master.
package ahb_mem_test_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR      = 3'd1;
  localparam state_t ST_WR_LAST = 3'd2;
  localparam state_t ST_RD      = 3'd3;
  localparam state_t ST_RD_LAST = 3'd4;
  localparam state_t ST_FIN     = 3'd5;

  function automatic logic [31:0] pattern(
    input logic [31:0] seed,
    input logic [15:0] idx
  );
    return seed ^ {idx, ~idx};
  endfunction

endpackage

// File: rtl/ahb_mem_test_if.sv
// AHB-Lite single-master bus bundle between the test
// master and the memory-controller slave port.
interface ahb_mem_test_if #(
  parameter int ADDR_W = 28
);
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [31:0]       HWDATA;
  logic [31:0]       HRDATA;
  logic              HREADY;
  logic [1:0]        HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE,
    output HSIZE, HBURST, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE,
    input  HSIZE, HBURST, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_mem_test_cmp.sv
// Read-data checker: saturating mismatch counter and
// latch of the first failing address.
module ahb_mem_test_cmp #(
  parameter int ADDR_W = 28,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [31:0]       rdata_i,
  input  logic [31:0]       exp_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [CNT_W-1:0]  err_count_o,
  output logic [ADDR_W-1:0] first_err_addr_o
);

  logic              have_q, have_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              miss;

  assign miss = en_i && (rdata_i != exp_i);

  always_comb begin
    have_d = have_q;
    cnt_d  = cnt_q;
    addr_d = addr_q;
    if (clr_i) begin
      have_d = 1'b0;
      cnt_d  = '0;
      addr_d = '0;
    end else if (miss) begin
      if (cnt_q != '1)
        cnt_d = cnt_q + CNT_W'(1);
      if (!have_q) begin
        have_d = 1'b1;
        addr_d = addr_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      have_q <= 1'b0;
      cnt_q  <= '0;
      addr_q <= '0;
    end else begin
      have_q <= have_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
    end
  end

  assign err_count_o      = cnt_q;
  assign first_err_addr_o = addr_q;

endmodule

// File: rtl/ahb_mem_test_master.sv
// AHB-Lite master that writes a seeded pattern to SRAM,
// reads it back and reports mismatches and bus errors.
module ahb_mem_test_master
  import ahb_mem_test_pkg::*;
#(
  parameter int                ADDR_W    = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                WORDS     = 1024,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              bus_error,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  ahb_mem_test_if.master    bus
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  dj_q, dj_d;
  logic [31:0]       seed_q, seed_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [31:0]       hwdata_q, hwdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              berr_q, berr_d;
  logic              abort_q, abort_d;
  logic              rdv_q, rdv_d;
  logic              clr, cmp_en, last, err_hit;
  logic [31:0]       cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;

  assign last    = idx_q == CNT_W'(WORDS - 1);
  assign cmp_exp = pattern(seed_q, 16'(dj_q));
  assign cmp_addr = BASE_ADDR + (ADDR_W'(dj_q) << 2);
  assign err_hit = (state_q != ST_IDLE) && (state_q != ST_FIN)
                && !abort_q && !bus.HREADY
                && (bus.HRESP == HRESP_ERROR);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dj_d     = dj_q;
    seed_d   = seed_q;
    htrans_d = htrans_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hwdata_d = hwdata_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    berr_d   = berr_q;
    abort_d  = abort_q;
    rdv_d    = rdv_q;
    clr      = 1'b0;
    cmp_en   = 1'b0;
    if (err_hit) begin
      // cancel the pipelined address, drain the erroring phase
      htrans_d = HTRANS_IDLE;
      berr_d   = 1'b1;
      abort_d  = 1'b1;
      state_d  = hwrite_q ? ST_WR_LAST : ST_RD_LAST;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start && !done_q) begin
          clr      = 1'b1;
          seed_d   = seed;
          busy_d   = 1'b1;
          pass_d   = 1'b0;
          berr_d   = 1'b0;
          abort_d  = 1'b0;
          rdv_d    = 1'b0;
          idx_d    = '0;
          htrans_d = HTRANS_NONSEQ;
          hwrite_d = 1'b1;
          haddr_d  = BASE_ADDR;
          state_d  = ST_WR;
        end
        ST_WR, ST_RD: if (bus.HREADY) begin
          if (state_q == ST_WR) begin
            hwdata_d = pattern(seed_q, 16'(idx_q));
          end else begin
            cmp_en = rdv_q;
            dj_d   = idx_q;
            rdv_d  = 1'b1;
          end
          if (last) begin
            htrans_d = HTRANS_IDLE;
            state_d  = (state_q == ST_WR) ? ST_WR_LAST
                                          : ST_RD_LAST;
          end else begin
            idx_d   = idx_q + CNT_W'(1);
            haddr_d = haddr_q + ADDR_W'(4);
          end
        end
        ST_WR_LAST: if (bus.HREADY) begin
          if (abort_q) begin
            state_d = ST_FIN;
          end else begin
            idx_d    = '0;
            rdv_d    = 1'b0;
            htrans_d = HTRANS_NONSEQ;
            hwrite_d = 1'b0;
            haddr_d  = BASE_ADDR;
            state_d  = ST_RD;
          end
        end
        ST_RD_LAST: if (bus.HREADY) begin
          cmp_en  = !abort_q;
          state_d = ST_FIN;
        end
        ST_FIN: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_count == '0) && !berr_q;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      dj_q     <= '0;
      seed_q   <= '0;
      htrans_q <= HTRANS_IDLE;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hwdata_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      berr_q   <= 1'b0;
      abort_q  <= 1'b0;
      rdv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dj_q     <= dj_d;
      seed_q   <= seed_d;
      htrans_q <= htrans_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hwdata_q <= hwdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      berr_q   <= berr_d;
      abort_q  <= abort_d;
      rdv_q    <= rdv_d;
    end
  end

  ahb_mem_test_cmp #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_cmp (
    .clk              (clk),
    .reset            (reset),
    .clr_i            (clr),
    .en_i             (cmp_en),
    .rdata_i          (bus.HRDATA),
    .exp_i            (cmp_exp),
    .addr_i           (cmp_addr),
    .err_count_o      (err_count),
    .first_err_addr_o (first_err_addr)
  );

  assign bus.HTRANS = htrans_q;
  assign bus.HADDR  = haddr_q;
  assign bus.HWRITE = hwrite_q;
  assign bus.HWDATA = hwdata_q;
  assign bus.HSIZE  = HSIZE_WORD;
  assign bus.HBURST = HBURST_SINGLE;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign bus_error  = berr_q;

endmodule
